// File: rtl/scene_host.sv
// scene_host: player view state plus NUM_SPHERES sphere slots, published on a
// packed out_bus for the tracer. Rotate/move commands walk a 3-state update
// FSM (CALC -> CHECK -> COMMIT) with per-axis saturating bounds.
// Optional: define SCENE_HOST_COLLISION_EN to reject moves that land inside
// any non-zero-radius sphere (Manhattan distance).
module scene_host #(
   parameter int NUM_SPHERES = 2,
   parameter int COORD_W     = 10,
   parameter int HEIGHT_W    = 8,
   parameter int STEP        = 4,
   parameter int NORM_MAG    = 1,
   parameter int VIEW_DIST   = 2,
   localparam int P  = 2*COORD_W + HEIGHT_W,
   localparam int V  = 2*(COORD_W+1) + (HEIGHT_W+1),
   localparam int PW = P + V + 9,
   localparam int SW = P + 20
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  rotate,
   input  logic [1:0]                  move,
   input  logic                        sph_we,
   input  logic [2:0]                  sph_idx,
   input  logic [SW-1:0]               sph_data,
   output logic                        upd_pulse,
   output logic [PW+SW*NUM_SPHERES-1:0] out_bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] CHECK  = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   // Two guard bits: one for sign, one for overflow past the top of range.
   localparam int XW = COORD_W + 2;
   localparam logic signed [XW-1:0]      STP  = XW'(STEP);
   localparam logic signed [XW-1:0]      CMAX = XW'((1 << COORD_W) - 1);
   localparam logic signed [COORD_W:0]   NMAG = (COORD_W+1)'(NORM_MAG);

   // Heading direction table, returned as {neg, pos} per axis.
   function automatic logic [1:0] dir_x(input logic [2:0] h);
      case (h)
         3'd0, 3'd1, 3'd7: return 2'b01;
         3'd3, 3'd4, 3'd5: return 2'b10;
         default:          return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] dir_y(input logic [2:0] h);
      case (h)
         3'd1, 3'd2, 3'd3: return 2'b01;
         3'd5, 3'd6, 3'd7: return 2'b10;
         default:          return 2'b00;
      endcase
   endfunction

   function automatic logic [COORD_W-1:0] sat(input logic signed [XW-1:0] v);
      if (v < 0)         return '0;
      else if (v > CMAX) return '1;
      else               return v[COORD_W-1:0];
   endfunction

   logic [1:0]                          state_q;
   logic [1:0]                          rot_q, mv_q;
   logic [2:0]                          h_q, h_n_q;
   logic [COORD_W-1:0]                  x_q, y_q, x_n_q, y_n_q;
   logic signed [XW-1:0]                tx_q, ty_q;
   logic                                upd_q;
   logic [NUM_SPHERES-1:0][SW-1:0]      sph_q;

   logic [2:0]                          h_calc;
   logic [1:0]                          dxc, dyc, dxh, dyh;
   logic                                fwd, bwd;
   logic signed [XW-1:0]                tx_calc, ty_calc;
   logic [COORD_W-1:0]                  sx, sy;
   logic signed [COORD_W:0]             nx, ny;
   logic                                reject;

   assign cmd_ready = (state_q == IDLE);
   assign upd_pulse = upd_q;
   assign sx        = sat(tx_q);
   assign sy        = sat(ty_q);

   // CALC datapath: rotate first, then move along the new heading.
   always_comb begin
      h_calc = h_q;
      if (rot_q == 2'b10)      h_calc = h_q + 3'd1;
      else if (rot_q == 2'b01) h_calc = h_q - 3'd1;
      dxc     = dir_x(h_calc);
      dyc     = dir_y(h_calc);
      fwd     = (mv_q == 2'b10);
      bwd     = (mv_q == 2'b01);
      tx_calc = $signed({2'b00, x_q});
      ty_calc = $signed({2'b00, y_q});
      if ((bwd && dxc[0]) || (fwd && dxc[1]))      tx_calc = tx_calc + STP;
      else if ((bwd && dxc[1]) || (fwd && dxc[0])) tx_calc = tx_calc - STP;
      if ((bwd && dyc[0]) || (fwd && dyc[1]))      ty_calc = ty_calc + STP;
      else if ((bwd && dyc[1]) || (fwd && dyc[0])) ty_calc = ty_calc - STP;
   end

`ifdef SCENE_HOST_COLLISION_EN
   logic [NUM_SPHERES-1:0] hit;
   for (genvar g = 0; g < NUM_SPHERES; g++) begin : g_coll
      logic [COORD_W-1:0] cx, cy, dxa, dya;
      logic [7:0]         rad;
      logic [XW-1:0]      dist;
      assign cx   = sph_q[g][HEIGHT_W+COORD_W +: COORD_W];
      assign cy   = sph_q[g][HEIGHT_W +: COORD_W];
      assign rad  = sph_q[g][P +: 8];
      assign dxa  = (sx >= cx) ? sx - cx : cx - sx;
      assign dya  = (sy >= cy) ? sy - cy : cy - sy;
      assign dist = XW'(dxa) + XW'(dya);
      assign hit[g] = (rad != 8'd0) && (dist < XW'(rad));
   end
   assign reject = |hit;
`else
   assign reject = 1'b0;
`endif

   // Update FSM: latch command, compute, saturate/check, commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rot_q   <= '0;
         mv_q    <= '0;
         h_q     <= '0;
         h_n_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         x_n_q   <= '0;
         y_n_q   <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid) begin
               rot_q   <= rotate;
               mv_q    <= move;
               state_q <= CALC;
            end
            CALC: begin
               h_n_q   <= h_calc;
               tx_q    <= tx_calc;
               ty_q    <= ty_calc;
               state_q <= CHECK;
            end
            CHECK: begin
               x_n_q   <= reject ? x_q : sx;
               y_n_q   <= reject ? y_q : sy;
               state_q <= COMMIT;
            end
            default: begin
               h_q     <= h_n_q;
               x_q     <= x_n_q;
               y_q     <= y_n_q;
               upd_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Sphere slot writes, only while idle; out-of-range indices match no slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sph_q <= '0;
      end else if (sph_we && cmd_ready) begin
         for (int i = 0; i < NUM_SPHERES; i++)
            if (sph_idx == 3'(i)) sph_q[i] <= sph_data;
      end
   end

   // Normal derived from the committed heading.
   always_comb begin
      dxh = dir_x(h_q);
      dyh = dir_y(h_q);
      nx  = dxh[0] ? NMAG : (dxh[1] ? -NMAG : '0);
      ny  = dyh[0] ? NMAG : (dyh[1] ? -NMAG : '0);
   end

   assign out_bus = {sph_q, 1'b0, 8'(VIEW_DIST), nx, ny, {(HEIGHT_W+1){1'b0}},
                     x_q, y_q, {HEIGHT_W{1'b0}}};

endmodule

// File: tb/tb_scene_host.sv
// Directed bench for scene_host with default parameters.
module tb_scene_host;
   localparam int NS = 2;
   localparam int P  = 28;
   localparam int V  = 31;
   localparam int PW = 68;
   localparam int SW = 48;
   localparam logic [SW-1:0] S1 = {12'hFFF, 8'd8, 10'd8, 10'd0, 8'd16};

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, sph_we, upd_pulse;
   logic [1:0]        rotate, move;
   logic [2:0]        sph_idx;
   logic [SW-1:0]     sph_data;
   logic [PW+SW*NS-1:0] out_bus;

   int vectors    = 0;
   int miscompares = 0;

   scene_host dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rotate(rotate), .move(move), .sph_we(sph_we), .sph_idx(sph_idx),
      .sph_data(sph_data), .upd_pulse(upd_pulse), .out_bus(out_bus)
   );

   always #5 clk = ~clk;

   logic [9:0]  px, py;
   logic [7:0]  pz, vd;
   logic [10:0] nx, ny;
   logic [8:0]  nz;
   logic        le;
   logic [SW-1:0] slot0, slot1;
   assign pz    = out_bus[0 +: 8];
   assign py    = out_bus[8 +: 10];
   assign px    = out_bus[18 +: 10];
   assign nz    = out_bus[P +: 9];
   assign ny    = out_bus[P+9 +: 11];
   assign nx    = out_bus[P+20 +: 11];
   assign vd    = out_bus[P+V +: 8];
   assign le    = out_bus[P+V+8];
   assign slot0 = out_bus[PW +: SW];
   assign slot1 = out_bus[PW+SW +: SW];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_player(input string tag, input int x, input int y,
                             input logic [10:0] enx, input logic [10:0] eny);
      chk({tag, ".x"}, px, 64'(x));
      chk({tag, ".y"}, py, 64'(y));
      chk({tag, ".z"}, pz, 0);
      chk({tag, ".nx"}, nx, enx);
      chk({tag, ".ny"}, ny, eny);
      chk({tag, ".nz"}, nz, 0);
   endtask

   // One command with full handshake timing checks; poke drives a sphere
   // write into the first busy cycle, which must be dropped.
   task automatic cmd(input logic [1:0] rot, input logic [1:0] mv, input bit poke);
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_pulse", upd_pulse, 0);
      cmd_valid = 1'b1; rotate = rot; move = mv;
      @(negedge clk);
      cmd_valid = 1'b0; rotate = 2'b00; move = 2'b00;
      for (int k = 0; k < 3; k++) begin
         chk("busy_ready", cmd_ready, 0);
         chk("busy_pulse", upd_pulse, 0);
         if (poke && k == 0) begin
            sph_we = 1'b1; sph_idx = 3'd1; sph_data = '1;
         end
         @(negedge clk);
         sph_we = 1'b0;
      end
      chk("done_ready", cmd_ready, 1);
      chk("done_pulse", upd_pulse, 1);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [SW-1:0] d);
      @(negedge clk);
      sph_we = 1'b1; sph_idx = idx; sph_data = d;
      @(negedge clk);
      sph_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int ex;

   initial begin
      rst_n = 1'b1; cmd_valid = 1'b0; rotate = '0; move = '0;
      sph_we = 1'b0; sph_idx = '0; sph_data = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_player("reset", 0, 0, 11'd1, 11'd0);
      chk("reset.vd", vd, 2);
      chk("reset.light", le, 0);
      chk("reset.ready", cmd_ready, 1);
      chk("reset.pulse", upd_pulse, 0);
      chk("reset.slot0", slot0, 0);
      chk("reset.slot1", slot1, 0);
      rst_n = 1'b1;

      // sphere writes: valid slot, out-of-range index
      wr(3'd1, S1);
      chk("sph.slot1", slot1, S1);
      chk("sph.slot0", slot0, 0);
      wr(3'd5, '1);
      chk("sph5.slot0", slot0, 0);
      chk("sph5.slot1", slot1, S1);

      // backward at h0 next to the sphere; busy write is dropped
      cmd(2'b00, 2'b01, 1'b1);
`ifdef SCENE_HOST_COLLISION_EN
      ex = 0;
`else
      ex = 4;
`endif
      chk_player("coll", ex, 0, 11'd1, 11'd0);
      chk("busy_wr.slot1", slot1, S1);

      do_reset();
      chk_player("reset2", 0, 0, 11'd1, 11'd0);
      chk("reset2.slot1", slot1, 0);

      cmd(2'b00, 2'b01, 1'b0);
      chk_player("bwd", 4, 0, 11'd1, 11'd0);
      cmd(2'b00, 2'b10, 1'b0);
      chk_player("fwd", 0, 0, 11'd1, 11'd0);
      cmd(2'b00, 2'b10, 1'b0);
      chk_player("fwd_sat0", 0, 0, 11'd1, 11'd0);
      cmd(2'b01, 2'b00, 1'b0);
      chk_player("right_h7", 0, 0, 11'd1, 11'h7FF);
      cmd(2'b10, 2'b00, 1'b0);
      chk_player("left_h0", 0, 0, 11'd1, 11'd0);
      cmd(2'b10, 2'b01, 1'b0);
      chk_player("left_bwd_h1", 4, 4, 11'd1, 11'd1);
      cmd(2'b11, 2'b11, 1'b0);
      chk_player("nop", 4, 4, 11'd1, 11'd1);
      cmd(2'b01, 2'b10, 1'b0);
      chk_player("right_fwd_h0", 0, 4, 11'd1, 11'd0);

      for (int i = 0; i < 255; i++) cmd(2'b00, 2'b01, 1'b0);
      chk_player("x1020", 1020, 4, 11'd1, 11'd0);
      cmd(2'b00, 2'b01, 1'b0);
      chk_player("x_sat1023", 1023, 4, 11'd1, 11'd0);
      cmd(2'b00, 2'b10, 1'b0);
      chk_player("x1019", 1019, 4, 11'd1, 11'd0);

      for (int i = 0; i < 4; i++) cmd(2'b10, 2'b00, 1'b0);
      chk_player("h4", 1019, 4, 11'h7FF, 11'd0);
      cmd(2'b00, 2'b01, 1'b0);
      chk_player("h4_bwd", 1015, 4, 11'h7FF, 11'd0);

      // reset in the middle of a command
      @(negedge clk);
      cmd_valid = 1'b1; move = 2'b01;
      @(negedge clk);
      cmd_valid = 1'b0; move = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_player("midrst", 0, 0, 11'd1, 11'd0);
      chk("midrst.ready", cmd_ready, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst.pulse", upd_pulse, 0);
         chk("midrst.x", px, 0);
      end
      cmd(2'b00, 2'b01, 1'b0);
      chk_player("post_rst_bwd", 4, 0, 11'd1, 11'd0);
      @(negedge clk);
      chk("final_pulse", upd_pulse, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
